// File: rtl/conv_array_driver_if.sv
// conv_array_driver_if: weight/row handshakes and kernel-array drive bus of conv_array_driver
//   master : driver side (drives o_* outputs, takes i_* inputs)
//   slave  : environment side (line buffer, weight source, kernel array)
//   Signals: i_w_valid/i_w_data/o_w_ready weight load, i_start window start,
//            i_row_valid/i_row_data/o_row_ready row segments, o_pixel_bus/o_weight/o_clear
//            to the array, o_busy/o_done status. Element width from `DATA_WIDTH.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
interface conv_array_driver_if #(
    parameter int ARRAY_SIZE  = 6,
    parameter int KERNEL_SIZE = 3
);
    localparam int DW = `DATA_WIDTH;
    logic                                    i_w_valid;
    logic [DW-1:0]                           i_w_data;
    logic                                    o_w_ready;
    logic                                    i_start;
    logic                                    i_row_valid;
    logic [(ARRAY_SIZE+KERNEL_SIZE-1)*DW-1:0] i_row_data;
    logic                                    o_row_ready;
    logic [ARRAY_SIZE*DW-1:0]                o_pixel_bus;
    logic [DW-1:0]                           o_weight;
    logic                                    o_clear;
    logic                                    o_busy;
    logic                                    o_done;
    modport master (
        input  i_w_valid, i_w_data, i_start, i_row_valid, i_row_data,
        output o_w_ready, o_row_ready, o_pixel_bus, o_weight, o_clear, o_busy, o_done
    );
    modport slave (
        output i_w_valid, i_w_data, i_start, i_row_valid, i_row_data,
        input  o_w_ready, o_row_ready, o_pixel_bus, o_weight, o_clear, o_busy, o_done
    );
endinterface

// File: rtl/conv_array_driver.sv
// conv_array_driver: feeds a KxK weight set and shifted row segments to a convolution kernel array
//   clk   : clock
//   rst_n : synchronous reset, active-high
//   bus   : conv_array_driver_if.master (weight load, start, row segments, array drive, busy/done)
//   Optional macro CONV_DRIVER_SKIP_ZERO_EN: taps whose weight is exactly zero are not issued.
//   All outputs are registered from the next-state values, so they line up with the state.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module conv_array_driver #(
    parameter int ARRAY_SIZE     = 6,
    parameter int KERNEL_SIZE    = 3,
    parameter int KERNEL_LATENCY = 2
) (
    input logic                clk,
    input logic                rst_n,
    conv_array_driver_if.master bus
);
    localparam int DW = `DATA_WIDTH;
    localparam int K  = KERNEL_SIZE;
    localparam int NW = K * K;
    localparam int SW = ARRAY_SIZE + K - 1;
    localparam int CW = $clog2(NW + 1);
    localparam int FW = $clog2(KERNEL_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, CLR, ROW, TAP, FLUSH, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    r, r_n, c, c_n, wcnt, widx;
    logic [FW-1:0]    f, f_n;
    logic [DW-1:0]    w [NW];
    logic [SW*DW-1:0] seg, seg_n;
    logic [K-1:0]     en;
    logic [CW:0]      first;
    logic             row_hs, w_hs;

    // First enabled tap at or after 'from'; MSB set means none remain in this row.
    function automatic logic [CW:0] seek(input logic [K-1:0] m, input int from);
        seek = {1'b1, {CW{1'b0}}};
        for (int j = K - 1; j >= 0; j--)
            if (j >= from && m[j]) seek = {1'b0, CW'(j)};
    endfunction

    function automatic logic [CW-1:0] wi(input logic [CW-1:0] rr, input logic [CW-1:0] cc);
        return CW'(int'(rr) * K + int'(cc));
    endfunction

`ifdef CONV_DRIVER_SKIP_ZERO_EN
    always_comb
        for (int j = 0; j < K; j++) en[j] = w[wi(r, CW'(j))] != '0;
`else
    assign en = '1;
`endif

    assign row_hs = bus.i_row_valid && bus.o_row_ready;
    assign w_hs   = bus.i_w_valid && bus.o_w_ready;
    assign first  = seek(en, state == TAP ? int'(c) + 1 : 0);

    always_comb begin
        state_n = state;
        r_n     = r;
        c_n     = c;
        f_n     = f;
        seg_n   = row_hs ? bus.i_row_data : seg;
        case (state)
            IDLE: state_n = (bus.i_start && wcnt == CW'(NW)) ? CLR : IDLE;
            CLR: begin
                state_n = ROW;
                r_n     = '0;
            end
            // A fresh row and the end of a tap share the same "next tap or next row" decision.
            ROW, TAP: if (state == TAP || row_hs) begin
                if (!first[CW]) begin
                    state_n = TAP;
                    c_n     = first[CW-1:0];
                end else if (r != CW'(K - 1)) begin
                    state_n = ROW;
                    r_n     = r + 1'b1;
                end else begin
                    state_n = FLUSH;
                    f_n     = '0;
                end
            end
            FLUSH: begin
                state_n = f == FW'(KERNEL_LATENCY - 1) ? DONE : FLUSH;
                f_n     = f + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state           <= IDLE;
            r               <= '0;
            c               <= '0;
            f               <= '0;
            wcnt            <= '0;
            widx            <= '0;
            bus.o_w_ready   <= 1'b0;
            bus.o_row_ready <= 1'b0;
            bus.o_pixel_bus <= '0;
            bus.o_weight    <= '0;
            bus.o_clear     <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
        end else begin
            state <= state_n;
            r     <= r_n;
            c     <= c_n;
            f     <= f_n;
            seg   <= seg_n;
            if (w_hs) begin
                wcnt <= wcnt == CW'(NW) ? wcnt : wcnt + 1'b1;
                widx <= widx == CW'(NW - 1) ? '0 : widx + 1'b1;
            end
            bus.o_w_ready   <= state_n == IDLE;
            bus.o_row_ready <= state_n == ROW;
            bus.o_pixel_bus <= state_n == TAP ? seg_n[(SW - int'(c_n)) * DW - 1 -: ARRAY_SIZE * DW] : '0;
            bus.o_weight    <= state_n == TAP ? w[wi(r_n, c_n)] : '0;
            bus.o_clear     <= state_n == CLR;
            bus.o_busy      <= state_n != IDLE;
            bus.o_done      <= state_n == DONE;
        end
    end

    always_ff @(posedge clk)
        if (!rst_n && w_hs) w[widx] <= bus.i_w_data;
endmodule

// File: tb/tb_conv_array_driver.sv
// tb_conv_array_driver: directed scoreboard bench for conv_array_driver with a kernel-array accumulator model
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module tb_conv_array_driver;
    localparam int AS = 6, K = 3, KL = 2, DW = `DATA_WIDTH, SW = AS + K - 1;
`ifdef CONV_DRIVER_SKIP_ZERO_EN
    localparam int SKIP_DONE = 9;
`else
    localparam int SKIP_DONE = 16;
`endif

    typedef struct {
        int start;
        int done;
        int sum [AS];
    } item_t;

    logic clk = 1'b0, rst_n = 1'b1;
    int   cyc = 0, win_start = 0, compared = 0, mismatched = 0;
    bit   probe = 1'b0;
    int   wt [K*K];
    int   rows [K][SW];
    int   acc [AS];
    item_t sb [$];
    logic [AS*DW-1:0] exp_pix;

    conv_array_driver_if #(.ARRAY_SIZE(AS), .KERNEL_SIZE(K)) bus ();
    conv_array_driver #(.ARRAY_SIZE(AS), .KERNEL_SIZE(K), .KERNEL_LATENCY(KL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [AS*DW-1:0] v, input int j);
        return v[(AS-j)*DW-1 -: DW];
    endfunction

    function automatic logic [SW*DW-1:0] seg_of(input int r);
        logic [SW*DW-1:0] s;
        for (int e = 0; e < SW; e++) s[(SW-e)*DW-1 -: DW] = DW'(rows[r][e]);
        return s;
    endfunction

    // Kernel-array model plus scoreboard pop on done.
    always @(negedge clk) if (!rst_n) begin
        for (int j = 0; j < AS; j++)
            acc[j] = bus.o_clear ? 0 : acc[j] + int'(lane(bus.o_pixel_bus, j)) * int'(bus.o_weight);
        if (probe && cyc - win_start + 1 == 1) check("clear_cycle1", bus.o_clear, 1);
        if (probe && cyc - win_start + 1 == 4) begin
            for (int j = 0; j < AS; j++) exp_pix[(AS-j)*DW-1 -: DW] = DW'(rows[0][j+1]);
            check("tap_r0c1_bus", bus.o_pixel_bus, exp_pix);
            check("tap_r0c1_weight", bus.o_weight, wt[1]);
        end
        if (bus.o_done) begin
            if (sb.size() == 0) check("unexpected_done", bus.o_done, 0);
            else begin
                item_t it;
                it = sb.pop_front();
                check("done_cycle", cyc - it.start + 1, it.done);
                for (int j = 0; j < AS; j++) check($sformatf("sum_lane%0d", j), acc[j], it.sum[j]);
            end
        end
    end

    task automatic pulse_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    task automatic send_w(input int v);
        bit hs;
        int n = 0;
        bus.i_w_valid = 1'b1;
        bus.i_w_data  = DW'(v);
        do begin @(negedge clk); hs = bus.o_w_ready; @(posedge clk); #1; n++; end while (!hs && n < 50);
        bus.i_w_valid = 1'b0;
        if (!hs) check("w_timeout", hs, 1);
    endtask

    task automatic send_row(input int r, input int stall);
        bit hs;
        int n = 0;
        if (stall > 0) begin
            do begin @(negedge clk); n++; end while (!bus.o_row_ready && n < 100);
            for (int i = 0; i < stall; i++) begin
                if (i > 0) @(negedge clk);
                check("stall_weight", bus.o_weight, 0);
                check("stall_bus", bus.o_pixel_bus, 0);
                @(posedge clk); #1;
            end
            n = 0;
        end
        bus.i_row_valid = 1'b1;
        bus.i_row_data  = seg_of(r);
        do begin @(negedge clk); hs = bus.o_row_ready; @(posedge clk); #1; n++; end while (!hs && n < 100);
        bus.i_row_valid = 1'b0;
        if (!hs) check("row_timeout", hs, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin @(posedge clk); n++; end
        if (sb.size() > 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run_window(input int stall_row, input int stall, input int exp_done, input bit hold);
        item_t it;
        for (int j = 0; j < AS; j++) begin
            it.sum[j] = 0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) it.sum[j] += wt[r*K+c] * rows[r][j+c];
        end
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = hold;
        it.start  = cyc;
        it.done   = exp_done;
        win_start = cyc;
        sb.push_back(it);
        for (int r = 0; r < K; r++) begin
            send_row(r, r == stall_row ? stall : 0);
            if (r == 1) bus.i_start = 1'b0;
        end
        wait_done();
    endtask

    task automatic load_all();
        for (int i = 0; i < K*K; i++) send_w(wt[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_w_valid = 1'b0; bus.i_w_data = '0; bus.i_start = 1'b0;
        bus.i_row_valid = 1'b0; bus.i_row_data = '0;
        for (int r = 0; r < K; r++)
            for (int e = 0; e < SW; e++) rows[r][e] = 10 * (r + 1) + e;

        // Reset held two clocks with start asserted.
        rst_n = 1'b1;
        bus.i_start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {bus.o_w_ready, bus.o_row_ready, bus.o_clear, bus.o_done, bus.o_weight}, 0);
        check("reset_bus", bus.o_pixel_bus, 0);
        check("reset_busy", bus.o_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_w_ready", bus.o_w_ready, 1);
        @(posedge clk); #1;

        // Basic window, rows always valid.
        wt = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_all();
        probe = 1'b1;
        run_window(-1, 0, 16, 1'b0);
        probe = 1'b0;

        // Row 1 withheld for 5 cycles.
        run_window(1, 5, 21, 1'b0);

        // Start with only 8 weights is ignored; start held during the window is ignored.
        pulse_reset();
        wt = '{2, 0, 1, 3, 1, 0, 2, 1, 5};
        for (int i = 0; i < K*K - 1; i++) send_w(wt[i]);
        bus.i_start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("short_busy", bus.o_busy, 0);
            check("short_clear", bus.o_clear, 0);
            @(posedge clk); #1;
        end
        bus.i_start = 1'b0;
        send_w(wt[K*K-1]);
        run_window(-1, 0, 16, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        check("single_done", sb.size(), 0);

        // Reset during a tap of row 1 aborts without done.
        pulse_reset();
        wt = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_all();
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        send_row(0, 0);
        send_row(1, 0);
        check("abort_tap_weight", bus.o_weight, wt[3]);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ctrl", {bus.o_w_ready, bus.o_row_ready, bus.o_clear, bus.o_done, bus.o_weight}, 0);
        check("abort_bus", bus.o_pixel_bus, 0);
        check("abort_busy", bus.o_busy, 0);
        @(posedge clk); #1;
        load_all();
        run_window(-1, 0, 16, 1'b0);

        // Sparse weights: zero taps skipped only with the skip macro.
        pulse_reset();
        wt = '{0, 2, 0, 0, 0, 0, 0, 0, 9};
        load_all();
        run_window(-1, 0, SKIP_DONE, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check("queue_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
